vram_bus_arbiter: RTL and testbench

//  Shares the single video RAM between the display fetch path and the host CPU. Display fetch is driven by the
//  DA counter plus the preload strobe; CPU accesses arrive over a req/ack handshake. Sits between the frame

---
 rtl/mc6847x_vram_pkg.sv | 25 ++
 rtl/vram_refresh_ctr.sv | 58 +++++
 rtl/vram_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_vram_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc6847x_vram_pkg.sv
// Shared types and defaults for the VRAM bus arbiter.
// FSM encodings, default widths and refresh row width.
package mc6847x_vram_pkg;

    localparam int VRAM_ADDR_W       = 13;
    localparam int VRAM_DATA_W       = 8;
    localparam int VRAM_MEM_LAT      = 2;
    localparam int VRAM_REFRESH_ROWS = 8;
    localparam int REF_ROW_W         = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
`ifdef VRAM_REFRESH_EN
        ,
        ST_REF  = 2'd3
`endif
    } arb_state_e;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/vram_refresh_ctr.sv
// DRAM refresh bookkeeping: HSn fall detect, pending queue, row counter.
// Only instantiated when VRAM_REFRESH_EN is defined.
module vram_refresh_ctr
    import mc6847x_vram_pkg::*;
#(
    parameter int ROWS = VRAM_REFRESH_ROWS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hsn,
    input  logic                 pop,
    output logic                 pend,
    output logic [REF_ROW_W-1:0] row
);

    localparam int QMAX = 2 * ROWS;
    localparam int QW   = $clog2(QMAX + 1);
    localparam logic [QW:0] ROWS_W = (QW + 1)'(ROWS);
    localparam logic [QW:0] QMAX_W = (QW + 1)'(QMAX);

    logic                 hsn_q, hsn_d;
    logic [QW-1:0]        queue_q, queue_d;
    logic [REF_ROW_W-1:0] row_q, row_d;
    logic                 fall;
    logic [QW:0]          sum;

    // Queue grows by ROWS per sync fall, shrinks per issued refresh.
    always_comb begin
        hsn_d = hsn;
        fall  = hsn_q & ~hsn;
        sum   = {1'b0, queue_q}
              + (fall ? ROWS_W : '0)
              - {{QW{1'b0}}, pop};
        if (sum > QMAX_W) begin
            queue_d = QMAX_W[QW-1:0];
        end else begin
            queue_d = sum[QW-1:0];
        end
        row_d = pop ? row_q + 1'b1 : row_q;
    end

    // State registers; hsn starts low so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsn_q   <= 1'b0;
            queue_q <= '0;
            row_q   <= '0;
        end else begin
            hsn_q   <= hsn_d;
            queue_q <= queue_d;
            row_q   <= row_d;
        end
    end

    assign pend = (queue_q != '0);
    assign row  = row_q;

endmodule

// File: rtl/vram_bus_arbiter.sv
// Arbitrates one VRAM between display fetch, host CPU and refresh.
// Optional DRAM refresh during HSn enabled by VRAM_REFRESH_EN.
module vram_bus_arbiter
    import mc6847x_vram_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int MEM_LAT      = VRAM_MEM_LAT,
    parameter int REFRESH_ROWS = VRAM_REFRESH_ROWS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              hsn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_refresh
);

    localparam int CNT_W = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              vid_pend_q, vid_pend_d;
    logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
    logic              vid_overrun_q, vid_overrun_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              grant_vid;

`ifdef VRAM_REFRESH_EN
    logic                 ref_pend;
    logic                 ref_pop;
    logic [REF_ROW_W-1:0] ref_row;
    logic                 mem_refresh_q, mem_refresh_d;

    vram_refresh_ctr #(
        .ROWS (REFRESH_ROWS)
    ) u_refresh_ctr (
        .clk   (clk),
        .reset (reset),
        .hsn   (hsn),
        .pop   (ref_pop),
        .pend  (ref_pend),
        .row   (ref_row)
    );

    assign mem_refresh = mem_refresh_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{hsn, 8'(REFRESH_ROWS)};
    assign mem_refresh = 1'b0;
`endif

    // Grant in IDLE, count down the access, then retire it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_oe_d    = mem_oe_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        grant_vid   = 1'b0;
`ifdef VRAM_REFRESH_EN
        ref_pop       = 1'b0;
        mem_refresh_d = mem_refresh_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (vid_pend_q) begin
                    grant_vid  = 1'b1;
                    state_d    = ST_VID;
                    cnt_d      = CNT_INIT;
                    mem_addr_d = vid_addr_q;
                    mem_oe_d   = 1'b1;
                end else if (!vid_req) begin
`ifdef VRAM_REFRESH_EN
                    if (ref_pend) begin
                        ref_pop       = 1'b1;
                        state_d       = ST_REF;
                        cnt_d         = CNT_INIT;
                        mem_addr_d    = ADDR_W'(ref_row);
                        mem_refresh_d = 1'b1;
                    end else
`endif
                    if (cpu_req && !cpu_ack_q) begin
                        state_d     = ST_CPU;
                        cnt_d       = CNT_INIT;
                        mem_addr_d  = cpu_addr;
                        mem_we_d    = cpu_we;
                        mem_oe_d    = ~cpu_we;
                        mem_wdata_d = cpu_we ? cpu_wdata : '0;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d     = ST_IDLE;
                    mem_addr_d  = '0;
                    mem_oe_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
`ifdef VRAM_REFRESH_EN
                    mem_refresh_d = 1'b0;
`endif
                    if (state_q == ST_VID) begin
                        vid_data_d  = mem_rdata;
                        vid_valid_d = 1'b1;
                    end
                    if (state_q == ST_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end
            end
        endcase
    end

    // Fetch strobes are latched every cycle; a repeat while pending is an overrun.
    always_comb begin
        vid_pend_d    = vid_req | (vid_pend_q & ~grant_vid);
        vid_addr_d    = vid_req ? vid_addr : vid_addr_q;
        vid_overrun_d = vid_overrun_q | (vid_req & vid_pend_q);
    end

    // FSM and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            mem_oe_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            vid_pend_q    <= 1'b0;
            vid_addr_q    <= '0;
            vid_overrun_q <= 1'b0;
            vid_data_q    <= '0;
            vid_valid_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
`ifdef VRAM_REFRESH_EN
            mem_refresh_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_oe_q      <= mem_oe_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            vid_pend_q    <= vid_pend_d;
            vid_addr_q    <= vid_addr_d;
            vid_overrun_q <= vid_overrun_d;
            vid_data_q    <= vid_data_d;
            vid_valid_q   <= vid_valid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
`ifdef VRAM_REFRESH_EN
            mem_refresh_q <= mem_refresh_d;
`endif
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_oe      = mem_oe_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign vid_overrun = vid_overrun_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: directed cases plus randomized CPU/video mix
// checked against a shadow-memory model and latency rules.
module tb_vram_bus_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int ROWS = 8;
    localparam int GAP  = 2 * LAT + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_overrun;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          hsn;
    logic [AW-1:0] mem_addr;
    logic          mem_oe;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_refresh;

    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    int n_cmp, n_err, cycle;
    int we_cyc, oe_cyc, vid_issued;
    bit vid_out;
    logic [AW-1:0] vid_exp;
    int vid_t, last_vid;

    vram_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MEM_LAT      (LAT),
        .REFRESH_ROWS (ROWS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .vid_overrun (vid_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .hsn         (hsn),
        .mem_addr    (mem_addr),
        .mem_oe      (mem_oe),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_refresh (mem_refresh)
    );

    initial forever #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {21'b0, vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ack,
                mem_addr, mem_oe, mem_we, mem_wdata, mem_refresh};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic cyc(input bit issue, input bit mon);
        if (issue && !vid_out && (cycle - last_vid) > GAP && $urandom_range(3) == 0) begin
            vid_req  = 1'b1;
            vid_addr = AW'(32 + $urandom_range(31));
            vid_exp  = vid_addr;
            vid_out  = 1'b1;
            vid_t    = cycle + 1;
            last_vid = cycle + 1;
            vid_issued++;
        end
        step();
        vid_req = 1'b0;
        if (mem_we) we_cyc++;
        if (mem_oe) oe_cyc++;
        if (mem_we && mem_oe) chk("oe_we_exclusive", {mem_oe, mem_we}, 2'b01);
        if (mon) begin
            if (vid_valid) begin
                chk("rnd_vid_expected", vid_out, 1);
                chk("rnd_vid_data", vid_data, shadow[vid_exp]);
                chk("rnd_vid_lat_ok",
                    (cycle - vid_t) >= LAT + 1 && (cycle - vid_t) <= 2 * LAT + 2, 1);
                vid_out = 1'b0;
            end else if (vid_out && (cycle - vid_t) > 2 * LAT + 2) begin
                chk("rnd_vid_timeout", vid_valid, 1);
                vid_out = 1'b0;
            end
        end
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit rnd, input bit hold,
                          output logic [DW-1:0] rd, output int acks);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        acks      = 0;
        rd        = '0;
        for (int k = 0; k < 40 && acks == 0; k++) begin
            cyc(rnd, rnd);
            if (cpu_ack) begin
                acks++;
                rd = cpu_rdata;
            end
        end
        if (acks == 0) chk("cpu_ack_timeout", cpu_ack, 1);
        if (hold) begin
            cyc(rnd, rnd);
            if (cpu_ack) acks++;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        cyc(rnd, rnd);
        if (cpu_ack) acks++;
        if (we) shadow[a] = d;
    endtask

    initial begin
        logic [DW-1:0] rd, v;
        logic [AW-1:0] a;
        int acks, tv, ta, nval, nwr, nrd;
        bit we;
`ifdef VRAM_REFRESH_EN
        int nref, ref_cyc, bad, vseen;
        bit vpend, vissued, prev;
`endif
        n_cmp = 0; n_err = 0; cycle = 0;
        we_cyc = 0; oe_cyc = 0; vid_issued = 0;
        vid_out = 0; vid_exp = '0; vid_t = 0; last_vid = 0;
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0; hsn = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram[i] = v;
            shadow[i] = v;
        end
        ram['h400] = 8'hA5; shadow['h400] = 8'hA5;
        ram['h500] = 8'h11; shadow['h500] = 8'h11;
        ram['h600] = 8'h22; shadow['h600] = 8'h22;

        repeat (3) step();
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        step();
        chk("idle_outputs", outs(), 0);

        // Case 1: idle video fetch, exact timing
        vid_req = 1'b1; vid_addr = 13'h0400;
        for (int k = 0; k <= LAT + 2; k++) begin
            step();
            vid_req = 1'b0;
            chk("t1_oe", mem_oe, (k >= 1 && k <= LAT));
            chk("t1_valid", vid_valid, (k == LAT + 1));
            if (k >= 1 && k <= LAT) chk("t1_addr", mem_addr, 13'h0400);
        end
        chk("t1_data", vid_data, 8'hA5);

        // Case 2: CPU write (req held in ack cycle), then readback
        we_cyc = 0; oe_cyc = 0;
        cpu_op(1'b1, 13'h0010, 8'h3C, 1'b0, 1'b1, rd, acks);
        chk("t2_we_cycles", we_cyc, LAT);
        chk("t2_oe_cycles", oe_cyc, 0);
        chk("t2_acks", acks, 1);
        chk("t2_rdata_kept", cpu_rdata, 8'h00);
        cpu_op(1'b0, 13'h0010, 8'h00, 1'b0, 1'b0, rd, acks);
        chk("t2_readback", rd, 8'h3C);
        chk("t2_read_oe", oe_cyc, LAT);
        chk("t2_read_acks", acks, 1);

        // Case 3: simultaneous CPU and video requests
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        vid_req = 1'b1; vid_addr = 13'h0400;
        tv = -1; ta = -1;
        for (int k = 0; k < 30 && (tv < 0 || ta < 0); k++) begin
            step();
            vid_req = 1'b0;
            if (vid_valid && tv < 0) tv = k;
            if (cpu_ack && ta < 0) begin
                ta = k;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("t3_vid_lat", tv, LAT + 1);
        chk("t3_ack_after_vid", ta - tv, LAT + 1);
        chk("t3_rdata", cpu_rdata, 8'h3C);
        chk("t3_vdata", vid_data, 8'hA5);
        chk("t3_no_overrun", vid_overrun, 0);
        step();

        // Case 4: two fetch strobes during a CPU access
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0011; cpu_wdata = 8'h77;
        step();
        vid_req = 1'b1; vid_addr = 13'h0500;
        step();
        vid_addr = 13'h0600;
        step();
        vid_req = 1'b0;
        nval = 0;
        for (int k = 0; k < 30; k++) begin
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_valid) nval++;
            step();
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        shadow['h11] = 8'h77;
        chk("t4_overrun", vid_overrun, 1);
        chk("t4_one_valid", nval, 1);
        chk("t4_second_addr", vid_data, 8'h22);

        // Case 6: reset in the middle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hEE;
        step();
        step();
        chk("t6_we_active", mem_we, 1);
        reset = 1'b1;
        step();
        chk("t6_we_dropped", mem_we, 0);
        chk("t6_outputs_zero", outs(), 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (cpu_ack) acks++;
        end
        chk("t6_no_ack", acks, 0);
        vid_req = 1'b1; vid_addr = 13'h0400;
        tv = -1;
        for (int k = 0; k < 10 && tv < 0; k++) begin
            step();
            vid_req = 1'b0;
            if (vid_valid) tv = k;
        end
        chk("t6_idle_latency", tv, LAT + 1);

        // Randomized CPU traffic with interleaved video fetches
        we_cyc = 0; oe_cyc = 0; vid_issued = 0; nwr = 0; nrd = 0;
        last_vid = cycle;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(1));
            a  = we ? AW'($urandom_range(31)) : AW'($urandom_range(63));
            v  = DW'($urandom);
            rd = shadow[a];
            if (we) nwr++; else nrd++;
            begin
                logic [DW-1:0] got;
                cpu_op(we, a, v, 1'b1, 1'($urandom_range(1)), got, acks);
                chk("rnd_acks", acks, 1);
                if (!we) chk("rnd_rdata", got, rd);
            end
        end
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1);
        chk("rnd_we_cycles", we_cyc, nwr * LAT);
        chk("rnd_oe_cycles", oe_cyc, (nrd + vid_issued) * LAT);
        chk("rnd_no_overrun", vid_overrun, 0);

`ifdef VRAM_REFRESH_EN
        // Case 5: refresh burst on HSn fall with a fetch mid-burst
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        hsn = 1'b1;
        step();
        step();
        hsn = 1'b0;
        nref = 0; ref_cyc = 0; bad = 0; vseen = 0;
        vpend = 0; vissued = 0; prev = 0;
        for (int k = 0; k < 120; k++) begin
            if (nref == 3 && mem_refresh && !vissued) begin
                vid_req = 1'b1; vid_addr = 13'h0400;
                vissued = 1; vpend = 1;
            end
            step();
            vid_req = 1'b0;
            if (vid_valid) begin
                vseen++;
                vpend = 0;
                chk("t5_vid_data", vid_data, 8'hA5);
            end
            if (mem_refresh && !prev) begin
                if (nref < 16) chk("t5_row", mem_addr, nref);
                if (vissued) chk("t5_vid_before_ref", vpend, 0);
                nref++;
            end
            if (mem_refresh) begin
                ref_cyc++;
                if (mem_oe || mem_we) bad++;
            end
            prev = mem_refresh;
        end
        hsn = 1'b1;
        chk("t5_ref_count", nref, ROWS);
        chk("t5_ref_cycles", ref_cyc, ROWS * LAT);
        chk("t5_ref_strobes_low", bad, 0);
        chk("t5_vid_served", vseen, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
